// File: rtl/sprite_pkg.sv
// Shared types and default sizing for the sprite fetch address generator.
// The descriptor struct is sized by the package defaults.
package sprite_pkg;

  localparam int unsigned NumSpritesDef = 16;
  localparam int unsigned AddrWDef      = 20;
  localparam int unsigned DimWDef       = 10;

  typedef struct packed {
    logic [AddrWDef-1:0] base;
    logic [DimWDef-1:0]  w;
    logic [DimWDef-1:0]  h;
  } sprite_desc_t;

  typedef enum logic [1:0] {
    StIdle,
    StLookup,
    StStream
  } agu_state_e;

  // A request produces no beats when the sprite is empty or the row is outside it.
  function automatic logic desc_reject(sprite_desc_t desc, logic mode, logic [DimWDef-1:0] row);
    return (desc.w == '0) || (desc.h == '0) || (mode && (row >= desc.h));
  endfunction

endpackage

// File: rtl/sprite_desc_table.sv
// Runtime-loadable sprite descriptor register file: one write port, one async read port.
module sprite_desc_table
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = NumSpritesDef,
  localparam int unsigned IDX_W      = $clog2(NUM_SPRITES)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               we,
  input  logic [IDX_W-1:0]   widx,
  input  sprite_desc_t       wdata,
  input  logic [IDX_W-1:0]   ridx,
  output sprite_desc_t       rdata
);

  sprite_desc_t mem_q [NUM_SPRITES];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < int'(NUM_SPRITES); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[widx] <= wdata;
    end
  end

  // Read returns the pre-edge contents, so a same-cycle write is not visible.
  assign rdata = mem_q[ridx];

endmodule

// File: rtl/sprite_fetch_agu.sv
// Sprite fetch address generator: looks up a descriptor and streams row-major SRAM
// pixel addresses for a whole sprite or a single row under valid/ready flow control.
module sprite_fetch_agu
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = NumSpritesDef,
  parameter int unsigned ADDR_W      = AddrWDef,
  parameter int unsigned DIM_W       = DimWDef,
  localparam int unsigned IDX_W      = $clog2(NUM_SPRITES)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [DIM_W-1:0]  cfg_w,
  input  logic [DIM_W-1:0]  cfg_h,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IDX_W-1:0]  req_sprite,
  input  logic              req_mode,
  input  logic [DIM_W-1:0]  req_row,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] Addr,
  output logic [DIM_W-1:0]  pix_x,
  output logic [DIM_W-1:0]  pix_y,
  output logic              last,
  output logic              busy,
  output logic              err
);

  agu_state_e          state_q;
  logic [IDX_W-1:0]    sprite_q;
  logic                mode_q;
  logic [DIM_W-1:0]    row_q;
  logic [DIM_W-1:0]    w_q;
  logic [DIM_W-1:0]    h_q;

  sprite_desc_t        wdesc;
  sprite_desc_t        rdesc;
  logic [2*DIM_W-1:0]  row_off;
  logic [ADDR_W-1:0]   start_addr;
  logic                lookup_bad;
  logic                lookup_last;
  logic                row_end;
  logic [DIM_W-1:0]    next_x;
  logic [DIM_W-1:0]    next_y;
  logic                next_last;

  assign wdesc = '{base: cfg_base, w: cfg_w, h: cfg_h};

  sprite_desc_table #(
    .NUM_SPRITES (NUM_SPRITES)
  ) u_table (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .we      (cfg_we),
    .widx    (cfg_idx),
    .wdata   (wdesc),
    .ridx    (sprite_q),
    .rdata   (rdesc)
  );

  always_comb begin
    row_off     = (2*DIM_W)'(row_q) * (2*DIM_W)'(rdesc.w);
    start_addr  = rdesc.base + (mode_q ? ADDR_W'(row_off) : '0);
    lookup_bad  = desc_reject(rdesc, mode_q, row_q);
    lookup_last = (rdesc.w == DIM_W'(1)) && (mode_q || (rdesc.h == DIM_W'(1)));
    row_end     = (pix_x == w_q - DIM_W'(1));
    next_x      = row_end ? '0 : pix_x + DIM_W'(1);
    next_y      = row_end ? pix_y + DIM_W'(1) : pix_y;
    next_last   = (next_x == w_q - DIM_W'(1)) && (mode_q || (next_y == h_q - DIM_W'(1)));
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StIdle;
      sprite_q   <= '0;
      mode_q     <= 1'b0;
      row_q      <= '0;
      w_q        <= '0;
      h_q        <= '0;
      addr_valid <= 1'b0;
      Addr       <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      last       <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            sprite_q <= req_sprite;
            mode_q   <= req_mode;
            row_q    <= req_row;
            state_q  <= StLookup;
          end
        end
        StLookup: begin
          if (lookup_bad) begin
            err     <= 1'b1;
            state_q <= StIdle;
          end else begin
            w_q        <= rdesc.w;
            h_q        <= rdesc.h;
            Addr       <= start_addr;
            pix_x      <= '0;
            pix_y      <= mode_q ? row_q : '0;
            last       <= lookup_last;
            addr_valid <= 1'b1;
            state_q    <= StStream;
          end
        end
        StStream: begin
          if (addr_ready) begin
            Addr  <= Addr + ADDR_W'(1);
            pix_x <= next_x;
            pix_y <= next_y;
            last  <= next_last && !last;
            if (last) begin
              addr_valid <= 1'b0;
              state_q    <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_fetch_agu.sv
// Self-checking bench for sprite_fetch_agu: a beat-list model built from the table contents
// plus literal pins on recorded transfers.
module tb_sprite_fetch_agu;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        cfg_we;
  logic [3:0]  cfg_idx;
  logic [19:0] cfg_base;
  logic [9:0]  cfg_w, cfg_h;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_sprite;
  logic        req_mode;
  logic [9:0]  req_row;
  logic        addr_valid;
  logic        addr_ready;
  logic [19:0] Addr;
  logic [9:0]  pix_x, pix_y;
  logic        last;
  logic        busy;
  logic        err;

  sprite_fetch_agu dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_base   (cfg_base),
    .cfg_w      (cfg_w),
    .cfg_h      (cfg_h),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sprite (req_sprite),
    .req_mode   (req_mode),
    .req_row    (req_row),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .Addr       (Addr),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .last       (last),
    .busy       (busy),
    .err        (err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [19:0] a;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       got_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          rand_rdy = 1'b0;
  logic [19:0] m_base [16];
  logic [9:0]  m_w [16];
  logic [9:0]  m_h [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Beat checker: every valid cycle must show the oldest outstanding expected beat.
  always @(negedge Clk) begin
    if (Reset_n === 1'b1 && addr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL beat_extra: got addr %0h, want no beat", Addr);
      end else begin
        chk("beat_addr", 32'(Addr), 32'(exp_q[0].a));
        chk("beat_x", 32'(pix_x), 32'(exp_q[0].x));
        chk("beat_y", 32'(pix_y), 32'(exp_q[0].y));
        chk("beat_last", 32'(last), 32'(exp_q[0].l));
        if (addr_ready) begin
          got_q.push_back('{a: Addr, x: pix_x, y: pix_y, l: last});
          void'(exp_q.pop_front());
        end
      end
    end
  end

  always @(posedge Clk) begin
    #1;
    addr_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic cfg_write(input int idx, input logic [19:0] b, input logic [9:0] w,
                           input logic [9:0] h);
    @(posedge Clk);
    #1;
    cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_base = b; cfg_w = w; cfg_h = h;
    m_base[idx] = b; m_w[idx] = w; m_h[idx] = h;
    @(posedge Clk);
    #1;
    cfg_we = 1'b0;
  endtask

  function automatic bit build_exp(input int idx, input bit mode, input int row);
    int w = int'(m_w[idx]);
    int h = int'(m_h[idx]);
    int y0, y1;
    if (w == 0 || h == 0 || (mode && row >= h)) return 1'b1;
    y0 = mode ? row : 0;
    y1 = mode ? row : h - 1;
    for (int y = y0; y <= y1; y++) begin
      for (int x = 0; x < w; x++) begin
        exp_q.push_back('{a: m_base[idx] + 20'(y * w + x), x: 10'(x), y: 10'(y),
                          l: (x == w - 1) && (y == y1)});
      end
    end
    return 1'b0;
  endfunction

  task automatic do_req(input int idx, input bit mode, input int row);
    bit bad;
    got_q.delete();
    chk("pre_req_ready", 32'(req_ready), 32'd1);
    @(posedge Clk);
    #1;
    req_valid = 1'b1; req_sprite = 4'(idx); req_mode = mode; req_row = 10'(row);
    @(posedge Clk);
    bad = build_exp(idx, mode, row);
    #1;
    req_valid = 1'b0;
    @(negedge Clk);
    chk("lookup_busy", 32'(busy), 32'd1);
    chk("lookup_ready", 32'(req_ready), 32'd0);
    chk("lookup_valid", 32'(addr_valid), 32'd0);
    @(negedge Clk);
    chk("post_err", 32'(err), 32'(bad));
    chk("post_valid", 32'(addr_valid), 32'(!bad));
    chk("post_ready", 32'(req_ready), 32'(bad));
  endtask

  task automatic wait_done();
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge Clk);
      if (!busy && exp_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stream_timeout: got %0d beats outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge Clk);
    chk("idle_err", 32'(err), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_base[i] = '0; m_w[i] = '0; m_h[i] = '0;
    end
    Reset_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_base = '0; cfg_w = '0; cfg_h = '0;
    req_valid = 1'b0; req_sprite = '0; req_mode = 1'b0; req_row = '0; addr_ready = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(addr_valid), 32'd0);
    chk("rst_addr", 32'(Addr), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Whole sprite 4x3
    cfg_write(2, 20'h01000, 10'd4, 10'd3);
    do_req(2, 1'b0, 0);
    wait_done();
    chk("m0_count", 32'(got_q.size()), 32'd12);
    if (got_q.size() == 12) begin
      chk("m0_first", 32'(got_q[0].a), 32'h01000);
      chk("m0_final", 32'(got_q[11].a), 32'h0100B);
      chk("m0_final_last", 32'(got_q[11].l), 32'd1);
      chk("m0_b11_last", 32'(got_q[10].l), 32'd0);
      chk("m0_b5_y", 32'(got_q[4].y), 32'd1);
      chk("m0_final_y", 32'(got_q[11].y), 32'd2);
    end

    // Single row 2
    do_req(2, 1'b1, 2);
    wait_done();
    chk("m1_count", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      chk("m1_first", 32'(got_q[0].a), 32'h01008);
      chk("m1_y", 32'(got_q[0].y), 32'd2);
      chk("m1_last", 32'(got_q[3].l), 32'd1);
    end

    // Rejected: row out of range, and zero-width sprite
    do_req(2, 1'b1, 3);
    wait_done();
    chk("bad_row_count", 32'(got_q.size()), 32'd0);
    cfg_write(5, 20'h00400, 10'd0, 10'd3);
    do_req(5, 1'b0, 0);
    wait_done();
    chk("bad_w_count", 32'(got_q.size()), 32'd0);

    // 1x1 sprite: first beat is also last
    cfg_write(9, 20'h00100, 10'd1, 10'd1);
    do_req(9, 1'b0, 0);
    wait_done();
    chk("one_count", 32'(got_q.size()), 32'd1);

    // Address wrap
    cfg_write(7, 20'hFFFFE, 10'd4, 10'd1);
    do_req(7, 1'b0, 0);
    wait_done();
    chk("wrap_count", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      chk("wrap_b2", 32'(got_q[1].a), 32'hFFFFF);
      chk("wrap_b3", 32'(got_q[2].a), 32'h00000);
      chk("wrap_b4", 32'(got_q[3].a), 32'h00001);
    end

    // Random backpressure plus rewrite of the active descriptor mid-stream
    rand_rdy = 1'b1;
    fork
      begin
        do_req(2, 1'b0, 0);
        wait_done();
      end
      begin
        repeat (6) @(posedge Clk);
        cfg_write(2, 20'h02000, 10'd6, 10'd6);
      end
    join
    rand_rdy = 1'b0;
    chk("bp_count", 32'(got_q.size()), 32'd12);
    if (got_q.size() == 12) chk("bp_final", 32'(got_q[11].a), 32'h0100B);

    // Reset mid-stream after beat 5
    cfg_write(2, 20'h01000, 10'd4, 10'd3);
    do_req(2, 1'b0, 0);
    for (int i = 0; i < 50 && got_q.size() < 5; i++) @(negedge Clk);
    chk("rst_pre_beats", 32'(got_q.size()), 32'd5);
    @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(addr_valid), 32'd0);
    chk("mid_rst_addr", 32'(Addr), 32'd0);
    chk("mid_rst_x", 32'(pix_x), 32'd0);
    chk("mid_rst_y", 32'(pix_y), 32'd0);
    chk("mid_rst_last", 32'(last), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      m_base[i] = '0; m_w[i] = '0; m_h[i] = '0;
    end
    repeat (2) @(negedge Clk);
    chk("in_rst_valid", 32'(addr_valid), 32'd0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("rel_req_ready", 32'(req_ready), 32'd1);
    do_req(2, 1'b0, 0);
    wait_done();
    chk("post_rst_count", 32'(got_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_fetch_agu.md
# sprite_fetch_agu

Programmable sprite descriptor table plus address generator that streams the SRAM pixel addresses of one sprite (whole sprite or a single row) to the SRAM read port under valid/ready flow control. Sits between the sprite drawing controller, which issues sprite requests, and the SRAM arbiter, which consumes one address per accepted beat. Replaces fixed compile-time sprite address mapping with a runtime-loadable table of base address, width and height.

## Interface
- NUM_SPRITES, 16, number of descriptor entries; IDX_W = $clog2(NUM_SPRITES)
- ADDR_W, 20, SRAM word address width
- DIM_W, 10, sprite width/height/coordinate width

- Clk  in  1  single clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  write descriptor cfg_idx this cycle
- cfg_idx  in  IDX_W  descriptor index
- cfg_base  in  ADDR_W  sprite start address
- cfg_w, cfg_h  in  DIM_W  sprite width, height in pixels
- req_valid  in  1  fetch request
- req_ready  out  1  high only in IDLE
- req_sprite  in  IDX_W  descriptor to fetch
- req_mode  in  1  0 = whole sprite, 1 = single row
- req_row  in  DIM_W  row for req_mode=1
- addr_valid  out  1  Addr/pix_x/pix_y/last valid
- addr_ready  in  1  consumer accepts beat
- Addr  out  ADDR_W  SRAM address of pixel
- pix_x, pix_y  out  DIM_W  pixel coordinate within sprite
- last  out  1  final beat of request
- busy  out  1  state != IDLE
- err  out  1  one-cycle pulse: rejected request

## Operation
- Table: NUM_SPRITES entries {base, w, h}, all zero at reset; written on cfg_we at clock edge; writable in any state.
- States: IDLE, LOOKUP, STREAM.
- IDLE: req_ready=1. req_valid&&req_ready latches sprite, mode, row; -> LOOKUP.
- LOOKUP: copy descriptor into working registers; compute start = base + (mode ? row*w : 0), row*w full 2*DIM_W product, sum truncated to ADDR_W (wraps modulo 2^ADDR_W). Set x=0, y=(mode?row:0). If w==0 or h==0, or mode=1 and row>=h: pulse err, -> IDLE, no beats. Else -> STREAM with addr_valid=1.
- STREAM: beat transfers when addr_valid&&addr_ready. On transfer: Addr+=1 (wrap), x+=1; if x==w-1 then x=0, y+=1. last=1 on beat where x==w-1 and (mode=1 or y==h-1). Transfer of last beat -> IDLE, addr_valid=0.
- Beats per request: w*h (mode 0) or w (mode 1); rows contiguous in SRAM, row-major.
- Backpressure: addr_ready low holds Addr, pix_x, pix_y, last stable and addr_valid high.
- Descriptor latched in LOOKUP; cfg writes to the active index during STREAM do not affect the current stream. cfg write to req_sprite in the LOOKUP cycle: LOOKUP reads old value.

## Timing
- Reset (any state, incl. mid-stream): state=IDLE, addr_valid=0, Addr=0, pix_x=0, pix_y=0, last=0, busy=0, err=0, table cleared; in-flight stream abandoned, no further beats. req_ready=1 after reset release.
- Accept at edge N -> LOOKUP in cycle N+1 -> first addr_valid in cycle N+2.
- Throughput: one beat per cycle while addr_ready=1.
- Last-beat transfer at edge M -> IDLE in cycle M+1; next request accepted earliest at edge M+1 (one bubble).
- err high for exactly the cycle after LOOKUP, together with req_ready=1.
- All outputs registered except req_ready and busy (decoded from state register).

## Structure
- sprite_pkg: sprite_desc_t struct {base, w, h}; agu_state_e enum {IDLE, LOOKUP, STREAM}; default parameter constants.
- Sub-module sprite_desc_table: NUM_SPRITES-entry register file, one write port, one async read port.
- Top: FSM, multiplier/adder for start address, x/y/address counters.

## Test plan
- Load idx 2 = {base 0x01000, w 4, h 3}; request mode 0, addr_ready=1 -> 12 beats, Addr 0x01000..0x0100B, pix_y steps 0,1,2, last only on beat 12, first addr_valid 2 cycles after accept.
- Same sprite, mode 1, row 2 -> 4 beats Addr 0x01008..0x0100B, pix_y=2, last on 4th.
- Mode 1, row 3 on h=3, and sprite with w=0 -> err pulse, zero beats, back to IDLE.
- Base 0xFFFFE, w 4, h 1 -> Addr 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- addr_ready toggled random during stream; cfg rewrite of active idx mid-stream -> outputs held while stalled, sequence unchanged, no beats lost or duplicated.
- Assert Reset_n low after beat 5 of 12 -> all outputs zero immediately, no further beats; new request after release streams from table cleared (err if reloaded table not written).
